intv_frame_sched: RTL and testbench
===================================

Name: intv_frame_sched

Overview:
- Frame-level scheduler in front of the data interleaver, clocked by cb_clk.
- Pulls coded bits from the upstream encoder over valid/ready and frames them into interleaver blocks: one SIGNAL block of 48 bits (BPSK), then cfg_n_sym DATA blocks at the configured modulation.
- Drives intv_din/intv_en/intv_con/signal_flag_in and watches intv_vld so that no block's write completes while the previous block is still being read out.
- Keeps the interleaver's ping-pong parity aligned so every SIGNAL block lands in buffer A.

Parameters:
SIG_INTV_RATIO, 4, cb_clk cycles per SIGNAL output bit; must match the interleaver's SIGNAL read pacing.
NSYM_W, 12, width of the data-symbol count.

Ports:
cb_clk  in  1  clock, 80 MHz
rst_n  in  1  asynchronous active-low reset
frame_start  in  1  one-cycle start pulse; samples cfg_* on the same cycle
cfg_map_type  in  2  DATA modulation: 00=48, 01=96, 10=192, 11=288 bits per symbol
cfg_n_sym  in  NSYM_W  number of DATA symbols, must be >=1
src_bit  in  1  coded bit from the encoder
src_vld  in  1  src_bit valid
src_rdy  out  1  scheduler accepts src_bit
intv_din  out  1  bit to the interleaver
intv_en  out  1  write strobe to the interleaver
intv_con  out  2  block type to the interleaver
signal_flag_in  out  1  marks the current block as SIGNAL
intv_vld  in  1  interleaver output strobe, used for read-completion tracking
busy  out  1  frame in progress
pad_active  out  1  pad symbol being written
frame_done  out  1  one-cycle pulse after the last block has been fully read
start_err  out  1  one-cycle pulse: frame_start received while busy (start ignored)

Behaviour:
- Reset: every output is 0; state=IDLE; all counters are 0; parity=A.
- Handshake: a bit is accepted when src_vld && src_rdy. On the next cycle intv_en=1 and intv_din=src_bit (1-cycle registered latency). When no bit is accepted, intv_en=0 and intv_din holds its value.
- Block length N: 48 in SIGNAL and SIG_DRAIN; otherwise taken from cfg_map_type latched at start.
- wr_cnt counts accepted bits of the current block, range 0..N-1, and wraps to 0 on the last bit.
- intv_con and signal_flag_in are registered and stay stable for the entire block.
- pend (0..1): set when the last bit of a DATA or PAD block is written; cleared when rd_cnt==N-1 and intv_vld=1.
  - rd_cnt counts intv_vld pulses, range 0..N-1, and wraps.
  - If set and clear occur in the same cycle, pend stays 1.
- Last-bit hold: in DATA_WR and PAD_WR, src_rdy is forced to 0 at wr_cnt==N-1 while pend=1.
- States:
  - IDLE: on frame_start, latch the config; need_pad = ~cfg_n_sym[0] (this makes the total block count even, so parity returns to A); go to SIG_WR.
  - SIG_WR: intv_con=00, signal_flag_in=1. After 48 bits, go to SIG_DRAIN.
  - SIG_DRAIN: src_rdy=0. Count 48 intv_vld pulses, then go to DATA_WR. This isolates the SIGNAL read from any DATA write end.
  - DATA_WR: intv_con=cfg_map_type, signal_flag_in=0. Each block end increments sym_cnt. When sym_cnt reaches n_sym: go to PAD_WR if need_pad, else FLUSH.
  - PAD_WR: src_rdy=0; intv_en=1 every cycle with intv_din=0; pad_active=1. Obeys the same last-bit hold. After N bits, go to FLUSH.
  - FLUSH: wait for pend=0 with no write outstanding; then frame_done=1 for one cycle, busy=0, go to IDLE.
- busy=1 in every state except IDLE.
- frame_start when not in IDLE: ignored, start_err pulses.
- A reset mid-frame returns everything to reset values immediately. The interleaver shares rst_n, so parity stays consistent.
- src_vld dropping mid-block simply stalls the writer; there is no timeout.

Decomposition:
- Shared package intv_pkg holds:
  - localparams N_48/N_96/N_192/N_288 and the block-length lookup function (2'b→9-bit);
  - state encoding IDLE, SIG_WR, SIG_DRAIN, DATA_WR, PAD_WR, FLUSH;
  - SIG_BITS=48.
- One natural sub-module, intv_rd_tracker: rd_cnt, pend, and the drain-done detection.

Test Plan:
- cfg_map_type=10, n_sym=3, src_vld held at 1 -> 48 SIGNAL writes with signal_flag_in=1; src_rdy stays low until 48 intv_vld pulses; then 3×192 DATA writes; no pad; frame_done after 3×192 DATA intv_vld pulses.
- n_sym=2, 00 -> after 2×48 DATA bits, 48 pad writes of 0 with pad_active=1; total intv_vld = 48+144 = 192.
- 11, n_sym=4, src always valid -> bit 287 of each block after the first is held until the previous block's 288th intv_vld; pend never exceeds 1.
- src_vld toggling 1/0 every cycle -> intv_en follows with 1-cycle lag; wr_cnt advances only on accepted bits; block boundaries are unchanged.
- frame_start while busy -> start_err pulse; no state change.
- rst_n asserted mid DATA_WR -> all outputs 0 asynchronously; a new frame_start after release completes normally.

Source files
------------

// File: rtl/intv_pkg.sv
// Shared definitions for the interleaver frame scheduler: block lengths,
// scheduler states and the modulation-to-block-length lookup.
package intv_pkg;

    localparam int BLK_LEN_W = 9;

    localparam logic [BLK_LEN_W-1:0] N_48  = 9'd48;
    localparam logic [BLK_LEN_W-1:0] N_96  = 9'd96;
    localparam logic [BLK_LEN_W-1:0] N_192 = 9'd192;
    localparam logic [BLK_LEN_W-1:0] N_288 = 9'd288;

    localparam logic [BLK_LEN_W-1:0] SIG_BITS = N_48;
    localparam logic [BLK_LEN_W-1:0] BLK_ONE  = 9'd1;

    typedef enum logic [2:0] {
        IDLE,
        SIG_WR,
        SIG_DRAIN,
        DATA_WR,
        PAD_WR,
        FLUSH
    } state_e;

    function automatic logic [BLK_LEN_W-1:0] blk_len_of(input logic [1:0] map_type);
        case (map_type)
            2'b00:   return N_48;
            2'b01:   return N_96;
            2'b10:   return N_192;
            default: return N_288;
        endcase
    endfunction

endpackage

// File: rtl/intv_rd_tracker.sv
// Follows the interleaver read side: counts intv_vld pulses per block and
// keeps the single "written block awaiting read-out" flag.
module intv_rd_tracker
    import intv_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [BLK_LEN_W-1:0] blk_len_i,
    input  logic                 intv_vld_i,
    input  logic                 pend_set_i,
    output logic                 pend_o,
    output logic                 rd_last_o
);

    logic [BLK_LEN_W-1:0] rd_cnt_q, rd_cnt_d;
    logic                 pend_q, pend_d;

    assign rd_last_o = intv_vld_i && (rd_cnt_q == blk_len_i - BLK_ONE);
    assign pend_o    = pend_q;

    always_comb begin
        rd_cnt_d = rd_cnt_q;
        if (intv_vld_i) begin
            rd_cnt_d = rd_last_o ? '0 : rd_cnt_q + BLK_ONE;
        end
        // A new block ending in the same cycle as the old read finishing keeps pend high.
        pend_d = pend_set_i ? 1'b1 : (rd_last_o ? 1'b0 : pend_q);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt_q <= '0;
            pend_q   <= 1'b0;
        end else begin
            rd_cnt_q <= rd_cnt_d;
            pend_q   <= pend_d;
        end
    end

endmodule

// File: rtl/intv_frame_sched.sv
// Frame scheduler ahead of the interleaver: one BPSK SIGNAL block, then the
// DATA blocks plus an optional pad block so ping-pong parity returns to A.
module intv_frame_sched
    import intv_pkg::*;
#(
    parameter int unsigned SIG_INTV_RATIO = 4,
    parameter int unsigned NSYM_W         = 12
) (
    input  logic              cb_clk,
    input  logic              rst_n,
    input  logic              frame_start,
    input  logic [1:0]        cfg_map_type,
    input  logic [NSYM_W-1:0] cfg_n_sym,
    input  logic              src_bit,
    input  logic              src_vld,
    output logic              src_rdy,
    output logic              intv_din,
    output logic              intv_en,
    output logic [1:0]        intv_con,
    output logic              signal_flag_in,
    input  logic              intv_vld,
    output logic              busy,
    output logic              pad_active,
    output logic              frame_done,
    output logic              start_err
);

    // The SIGNAL read pacing lives in the interleaver; a zero ratio cannot match it.
    if (SIG_INTV_RATIO == 0) begin : g_bad_ratio
        $error("SIG_INTV_RATIO must be at least 1");
    end

    localparam logic [NSYM_W-1:0] NSYM_ONE = 1;

    state_e               state_q, state_d;
    logic [1:0]           map_q;
    logic [NSYM_W-1:0]    n_sym_q;
    logic [NSYM_W-1:0]    sym_cnt_q;
    logic                 need_pad_q;
    logic [BLK_LEN_W-1:0] wr_cnt_q;
    logic                 intv_din_q, intv_en_q, sig_flag_q, pad_active_q;
    logic [1:0]           intv_con_q;
    logic                 frame_done_q, frame_done_d;
    logic                 start_err_q;

    logic [BLK_LEN_W-1:0] blk_len;
    logic                 wr_last, wr_hold, accept, pad_fire, wr_fire, blk_end, sym_last;
    logic                 pend_set, pend, rd_last;

    always_comb begin
        blk_len  = (state_q == SIG_WR || state_q == SIG_DRAIN) ? SIG_BITS : blk_len_of(map_q);
        wr_last  = (wr_cnt_q == blk_len - BLK_ONE);
        // The last bit of a block may not land while the previous block is still being read.
        wr_hold  = wr_last && pend && (state_q == DATA_WR || state_q == PAD_WR);
        src_rdy  = ((state_q == SIG_WR) || (state_q == DATA_WR)) && !wr_hold;
        accept   = src_vld && src_rdy;
        pad_fire = (state_q == PAD_WR) && !wr_hold;
        wr_fire  = accept || pad_fire;
        blk_end  = wr_fire && wr_last;
        pend_set = blk_end && (state_q == DATA_WR || state_q == PAD_WR);
        sym_last = (sym_cnt_q == n_sym_q - NSYM_ONE);
    end

    intv_rd_tracker u_rd_tracker (
        .clk        (cb_clk),
        .rst_n      (rst_n),
        .blk_len_i  (blk_len),
        .intv_vld_i (intv_vld),
        .pend_set_i (pend_set),
        .pend_o     (pend),
        .rd_last_o  (rd_last)
    );

    // NOTE: every variable driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        frame_done_d = 1'b0;
        unique case (state_q)
            IDLE:      if (frame_start) state_d = SIG_WR;
            SIG_WR:    if (blk_end) state_d = SIG_DRAIN;
            SIG_DRAIN: if (rd_last) state_d = DATA_WR;
            DATA_WR:   if (blk_end && sym_last) state_d = need_pad_q ? PAD_WR : FLUSH;
            PAD_WR:    if (blk_end) state_d = FLUSH;
            FLUSH: begin
                if (!pend && !intv_en_q) begin
                    state_d      = IDLE;
                    frame_done_d = 1'b1;
                end
            end
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge cb_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            map_q        <= 2'b00;
            n_sym_q      <= '0;
            sym_cnt_q    <= '0;
            need_pad_q   <= 1'b0;
            wr_cnt_q     <= '0;
            intv_din_q   <= 1'b0;
            intv_en_q    <= 1'b0;
            intv_con_q   <= 2'b00;
            sig_flag_q   <= 1'b0;
            pad_active_q <= 1'b0;
            frame_done_q <= 1'b0;
            start_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            frame_done_q <= frame_done_d;
            start_err_q  <= frame_start && (state_q != IDLE);
            intv_en_q    <= wr_fire;
            pad_active_q <= (state_q == PAD_WR);

            // Block attributes update with the write itself and then hold until the next block.
            if (wr_fire) begin
                intv_din_q <= pad_fire ? 1'b0 : src_bit;
                intv_con_q <= (state_q == SIG_WR) ? 2'b00 : map_q;
                sig_flag_q <= (state_q == SIG_WR);
                wr_cnt_q   <= wr_last ? '0 : wr_cnt_q + BLK_ONE;
            end

            if (state_q == IDLE && frame_start) begin
                map_q      <= cfg_map_type;
                n_sym_q    <= cfg_n_sym;
                need_pad_q <= ~cfg_n_sym[0];
                sym_cnt_q  <= '0;
            end else if (state_q == DATA_WR && blk_end) begin
                sym_cnt_q  <= sym_cnt_q + NSYM_ONE;
            end
        end
    end

    assign intv_din       = intv_din_q;
    assign intv_en        = intv_en_q;
    assign intv_con       = intv_con_q;
    assign signal_flag_in = sig_flag_q;
    assign pad_active     = pad_active_q;
    assign frame_done     = frame_done_q;
    assign start_err      = start_err_q;
    assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_intv_frame_sched.sv
// Frame-level bench for intv_frame_sched with a simple interleaver read model.
module tb_intv_frame_sched;

    localparam int NSYM_W = 12;
    localparam int RATIO  = 4;
    localparam int NV     = 6;
    localparam int BUDGET = 30000;

    logic              cb_clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              frame_start = 1'b0;
    logic [1:0]        cfg_map_type = 2'b00;
    logic [NSYM_W-1:0] cfg_n_sym = '0;
    logic              src_bit = 1'b0;
    logic              src_vld = 1'b0;
    logic              intv_vld = 1'b0;
    logic              src_rdy, intv_din, intv_en, signal_flag_in;
    logic [1:0]        intv_con;
    logic              busy, pad_active, frame_done, start_err;

    intv_frame_sched #(.SIG_INTV_RATIO(RATIO), .NSYM_W(NSYM_W)) dut (
        .cb_clk         (cb_clk),
        .rst_n          (rst_n),
        .frame_start    (frame_start),
        .cfg_map_type   (cfg_map_type),
        .cfg_n_sym      (cfg_n_sym),
        .src_bit        (src_bit),
        .src_vld        (src_vld),
        .src_rdy        (src_rdy),
        .intv_din       (intv_din),
        .intv_en        (intv_en),
        .intv_con       (intv_con),
        .signal_flag_in (signal_flag_in),
        .intv_vld       (intv_vld),
        .busy           (busy),
        .pad_active     (pad_active),
        .frame_done     (frame_done),
        .start_err      (start_err)
    );

    always #5 cb_clk = ~cb_clk;

    typedef struct {
        logic [1:0] map;
        int         n_sym;
        bit         toggle;
        bit         inject;
        int         exp_sig;
        int         exp_data;
        int         exp_pad;
        int         exp_vld;
    } vec_t;

    vec_t vecs [NV];

    int n_vec = 0;
    int n_err = 0;

    // Interleaver / source model state for the frame in progress.
    int         blk_len [$];
    int         total_blocks, nsym;
    logic [1:0] cur_map;
    bit         toggle, acc_prev, in_frame, done_seen;
    int         wr_blk, wr_in_blk, rd_blk, rd_left, rd_timer, vld_total, done_rd;
    int         acc_k, out_k, sig_w, data_w, pad_w;
    int         attr_err, din_err, lat_err, order_err, busy_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic pat(input int k);
        return k[0] ^ k[3] ^ k[5];
    endfunction

    function automatic int n_of(input logic [1:0] m);
        case (m)
            2'b00:   return 48;
            2'b01:   return 96;
            2'b10:   return 192;
            default: return 288;
        endcase
    endfunction

    function automatic logic [31:0] outs();
        return 32'({src_rdy, intv_din, intv_en, intv_con, signal_flag_in,
                    busy, pad_active, frame_done, start_err});
    endfunction

    task automatic init_model(input vec_t v);
        blk_len.delete();
        blk_len.push_back(48);
        for (int i = 0; i < v.n_sym; i++) blk_len.push_back(n_of(v.map));
        if (v.n_sym % 2 == 0) blk_len.push_back(n_of(v.map));
        total_blocks = blk_len.size();
        nsym = v.n_sym; cur_map = v.map; toggle = v.toggle;
        acc_prev = 0; in_frame = 0; done_seen = 0; done_rd = 0;
        wr_blk = 0; wr_in_blk = 0; rd_blk = 0; rd_left = 0; rd_timer = 0; vld_total = 0;
        acc_k = 0; out_k = 0; sig_w = 0; data_w = 0; pad_w = 0;
        attr_err = 0; din_err = 0; lat_err = 0; order_err = 0; busy_err = 0;
    endtask

    // One clock: observe registered outputs of the previous cycle, then drive this cycle.
    task automatic step();
        @(posedge cb_clk);
        #1;
        if (intv_en) begin
            if (wr_blk >= total_blocks) begin
                attr_err++;
            end else begin
                if (wr_blk >= 1 && rd_blk < 1) order_err++;
                if (wr_blk == 0) begin
                    sig_w++;
                    if (!signal_flag_in || intv_con != 2'b00 || pad_active) attr_err++;
                end else if (wr_blk <= nsym) begin
                    data_w++;
                    if (signal_flag_in || intv_con != cur_map || pad_active) attr_err++;
                end else begin
                    pad_w++;
                    if (!pad_active || intv_din || signal_flag_in || intv_con != cur_map) attr_err++;
                    if (acc_prev) lat_err++;
                end
                if (wr_blk <= nsym) begin
                    if (!acc_prev) lat_err++;
                    else if (intv_din !== pat(out_k)) din_err++;
                    out_k++;
                end
                wr_in_blk++;
                if (wr_in_blk == blk_len[wr_blk]) begin
                    if (rd_blk < wr_blk) order_err++;
                    wr_in_blk = 0;
                    wr_blk++;
                end
            end
        end else if (acc_prev) begin
            lat_err++;
        end

        if (frame_done) begin
            if (in_frame) begin
                done_seen = 1; done_rd = rd_blk; in_frame = 0;
                if (busy) busy_err++;
            end else begin
                busy_err++;
            end
        end else if (in_frame && !busy) begin
            busy_err++;
        end

        // Read model: a block is read out once fully written; SIGNAL slower than DATA.
        intv_vld = 1'b0;
        if (rd_left == 0 && rd_blk < wr_blk) begin
            rd_left = blk_len[rd_blk]; rd_timer = 0;
        end
        if (rd_left > 0) begin
            if (rd_timer == 0) begin
                intv_vld = 1'b1; vld_total++; rd_left--;
                rd_timer = (rd_blk == 0) ? RATIO - 1 : 1;
                if (rd_left == 0) rd_blk++;
            end else begin
                rd_timer--;
            end
        end

        src_vld  = toggle ? ~src_vld : 1'b1;
        src_bit  = pat(acc_k);
        acc_prev = src_vld && src_rdy;
        if (acc_prev) acc_k++;
    endtask

    task automatic run_frame(input vec_t v);
        int cyc;
        init_model(v);
        cfg_map_type = v.map;
        cfg_n_sym    = NSYM_W'(v.n_sym);
        frame_start  = 1'b1;
        in_frame     = 1;
        step();
        frame_start  = 1'b0;
        cyc = 0;
        while (!done_seen && cyc < BUDGET) begin
            if (v.inject && cyc == 10) begin
                frame_start  = 1'b1;
                cfg_map_type = ~v.map;
                cfg_n_sym    = NSYM_W'(1);
                step();
                frame_start  = 1'b0;
                cfg_map_type = v.map;
                cfg_n_sym    = NSYM_W'(v.n_sym);
                check("start_err_pulse", start_err, 1);
                step();
                check("start_err_clear", start_err, 0);
                cyc += 2;
            end else begin
                step();
                cyc++;
            end
        end
        check("frame_done_seen", done_seen, 1);
        check("sig_writes", sig_w, v.exp_sig);
        check("data_writes", data_w, v.exp_data);
        check("pad_writes", pad_w, v.exp_pad);
        check("vld_total", vld_total, v.exp_vld);
        check("blocks_read_at_done", done_rd, total_blocks);
        check("attr_errors", attr_err, 0);
        check("din_errors", din_err, 0);
        check("latency_errors", lat_err, 0);
        check("order_errors", order_err, 0);
        check("busy_errors", busy_err, 0);
    endtask

    initial begin
        //            map    nsym tog inj sig  data  pad  vld
        vecs[0] = '{2'b10, 3, 0, 0, 48, 576,  0,   624};
        vecs[1] = '{2'b00, 2, 0, 0, 48, 96,   48,  192};
        vecs[2] = '{2'b11, 4, 0, 0, 48, 1152, 288, 1488};
        vecs[3] = '{2'b01, 2, 1, 0, 48, 192,  96,  336};
        vecs[4] = '{2'b01, 3, 1, 1, 48, 288,  0,   336};
        vecs[5] = '{2'b00, 1, 0, 1, 48, 48,   0,   96};

        rst_n = 1'b0;
        repeat (2) @(posedge cb_clk);
        #1;
        check("reset_outputs", outs(), 0);
        @(negedge cb_clk);
        rst_n = 1'b1;
        @(posedge cb_clk);
        #1;

        for (int i = 0; i < NV; i++) run_frame(vecs[i]);

        // Asynchronous reset in the middle of DATA writes, then a clean frame.
        init_model(vecs[0]);
        cfg_map_type = vecs[0].map;
        cfg_n_sym    = NSYM_W'(vecs[0].n_sym);
        frame_start  = 1'b1;
        in_frame     = 1;
        step();
        frame_start  = 1'b0;
        for (int c = 0; c < 3000 && data_w < 100; c++) step();
        check("mid_reset_reached_data", data_w >= 100, 1);
        check("mid_reset_busy_before", busy, 1);
        #2;
        intv_vld = 1'b0;
        src_vld  = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("mid_reset_outputs", outs(), 0);
        @(negedge cb_clk);
        @(negedge cb_clk);
        rst_n = 1'b1;
        run_frame(vecs[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
